// File: rtl/ysyx_22050612_mem_arbiter_if.sv
// Bus bundle for the fetch / load-store memory arbiter: two requester ports plus the shared memory port.
// The arbiter uses the slave modport; the surrounding core and memory use the master modport.
interface ysyx_22050612_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_rdata;
    logic                  ifu_resp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with round-robin tie breaking and a watchdog that completes stalled transactions with an error.
module ysyx_22050612_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050612_mem_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_t;

    state_t              state_q, state_d;
    req_t                owner_q, owner_d;
    req_t                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;

    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic                ifu_resp_err_q, ifu_resp_err_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic                lsu_resp_err_q, lsu_resp_err_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic                arb_open;
    logic                grant_ifu;
    logic                grant_lsu;
    logic                resp_fire;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_data;

    // A requester wins when it is alone, or when the other one was served last.
    // The two grant terms are mutually exclusive, so at most one ready is ever high.
    assign arb_open  = (state_q == S_IDLE) && !rst;
    assign grant_ifu = arb_open && bus.ifu_req_valid &&
                       (!bus.lsu_req_valid || (last_grant_q == REQ_LSU));
    assign grant_lsu = arb_open && bus.lsu_req_valid &&
                       (!bus.ifu_req_valid || (last_grant_q == REQ_IFU));

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        cnt_d            = cnt_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = 1'b0;
        ifu_resp_err_d   = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_resp_valid_d = 1'b0;
        lsu_resp_err_d   = 1'b0;
        lsu_rdata_d      = lsu_rdata_q;
        resp_fire        = 1'b0;
        resp_err         = 1'b0;
        resp_data        = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_lsu) begin
                    mem_addr_d      = bus.lsu_addr;
                    mem_wen_d       = bus.lsu_wen;
                    mem_wdata_d     = bus.lsu_wdata;
                    mem_wmask_d     = bus.lsu_wmask;
                    owner_d         = REQ_LSU;
                    last_grant_d    = REQ_LSU;
                    mem_req_valid_d = 1'b1;
                    state_d         = S_ISSUE;
                end else if (grant_ifu) begin
                    mem_addr_d      = bus.ifu_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wmask_d     = '0;
                    owner_d         = REQ_IFU;
                    last_grant_d    = REQ_IFU;
                    mem_req_valid_d = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response landing on the final watchdog cycle still completes normally.
                if (bus.mem_resp_valid) begin
                    resp_fire = 1'b1;
                    resp_data = ((owner_q == REQ_LSU) && mem_wen_q) ? '0 : bus.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_fire) begin
            state_d = S_RESP;
            if (owner_q == REQ_IFU) begin
                ifu_resp_valid_d = 1'b1;
                ifu_resp_err_d   = resp_err;
                ifu_rdata_d      = resp_data;
            end else begin
                lsu_resp_valid_d = 1'b1;
                lsu_resp_err_d   = resp_err;
                lsu_rdata_d      = resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            owner_q          <= REQ_IFU;
            last_grant_q     <= REQ_IFU;
            cnt_q            <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            lsu_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_grant_q     <= last_grant_d;
            cnt_q            <= cnt_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_resp_err_q   <= ifu_resp_err_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_resp_err_q   <= lsu_resp_err_d;
            lsu_rdata_q      <= lsu_rdata_d;
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_resp_err   = ifu_resp_err_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_resp_err   = lsu_resp_err_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wmask      = mem_wmask_q;
endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Directed bench for the memory arbiter: fetch, round-robin ties, delayed store, watchdog and mid-flight reset.
module tb_ysyx_22050612_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ysyx_22050612_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22050612_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid});
        end
        n_checks++;
        if ({bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, bus.lsu_resp_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_resp: got %b expected 0000", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, bus.lsu_resp_err});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_fields: got addr %h wdata %h mask %h wen %b expected all 0", bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen);
        end
        n_checks++;
        if ({bus.ifu_rdata, bus.lsu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got ifu %h lsu %h expected 0", bus.ifu_rdata, bus.lsu_rdata);
        end
    endtask

    task automatic test_single_fetch();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h0000_0000_8000_0000;
        #1;
        n_checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_ready: got %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = 64'hFFFF_FFFF_FFFF_FFFF;
        n_checks++;
        if ({bus.mem_req_valid, bus.mem_wen, bus.mem_wmask} !== {1'b1, 1'b0, 8'h00} ||
            bus.mem_addr !== 64'h0000_0000_8000_0000) begin
            n_fail++;
            $display("FAIL fetch_issue: got valid %b wen %b mask %h addr %h expected 1 0 00 0000000080000000",
                     bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0000_0000_0000_0413;
        n_checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait_valid: got %b expected 0", bus.mem_req_valid);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        n_checks++;
        if ({bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid} !== 3'b100 ||
            bus.ifu_rdata !== 64'h413) begin
            n_fail++;
            $display("FAIL fetch_resp: got valid/err/lsu %b rdata %h expected 100 0000000000000413",
                     {bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid}, bus.ifu_rdata);
        end
        tick();
        n_checks++;
        if (bus.ifu_resp_valid !== 1'b0 || bus.ifu_rdata !== 64'h413) begin
            n_fail++;
            $display("FAIL fetch_after: got valid %b rdata %h expected 0 0000000000000413", bus.ifu_resp_valid, bus.ifu_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_lsu;
        logic        exp_wen;
        logic [63:0] exp_addr;
        logic [63:0] exp_rdata;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h200;
        bus.lsu_wdata     = 64'h1234;
        bus.lsu_wmask     = 8'hFF;
        for (int r = 0; r < 3; r++) begin
            exp_lsu   = (r != 1);
            exp_wen   = (r == 0);
            exp_addr  = exp_lsu ? 64'h200 : 64'h100;
            exp_rdata = (r == 0) ? 64'h0 : (64'hA0 + 64'(r));
            bus.lsu_wen = (r == 0);
            #1;
            n_checks++;
            if ({bus.lsu_req_ready, bus.ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got lsu/ifu ready %b expected %b", r,
                         {bus.lsu_req_ready, bus.ifu_req_ready}, {exp_lsu, !exp_lsu});
            end
            tick();
            n_checks++;
            if ({bus.mem_req_valid, bus.mem_wen, bus.lsu_req_ready, bus.ifu_req_ready} !== {1'b1, exp_wen, 2'b00} ||
                bus.mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rr_issue%0d: got valid/wen/readys %b addr %h expected %b %h", r,
                         {bus.mem_req_valid, bus.mem_wen, bus.lsu_req_ready, bus.ifu_req_ready}, bus.mem_addr,
                         {1'b1, exp_wen, 2'b00}, exp_addr);
            end
            if (!exp_lsu) begin
                n_checks++;
                if (bus.mem_wdata !== 64'h0 || bus.mem_wmask !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rr_ifu_fields: got wdata %h mask %h expected 0 00", bus.mem_wdata, bus.mem_wmask);
                end
            end
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 64'hA0 + 64'(r);
            #1;
            n_checks++;
            if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_wait_ready%0d: got %b expected 00", r, {bus.lsu_req_ready, bus.ifu_req_ready});
            end
            tick();
            bus.mem_resp_valid = 1'b0;
            n_checks++;
            if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_req_ready, bus.ifu_req_ready} !== {exp_lsu, !exp_lsu, 2'b00} ||
                (exp_lsu ? bus.lsu_rdata : bus.ifu_rdata) !== exp_rdata) begin
                n_fail++;
                $display("FAIL rr_resp%0d: got lsu/ifu valid+readys %b rdata lsu %h ifu %h expected %b %h", r,
                         {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_req_ready, bus.ifu_req_ready},
                         bus.lsu_rdata, bus.ifu_rdata, {exp_lsu, !exp_lsu, 2'b00}, exp_rdata);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_2000;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_checks++;
            if (bus.lsu_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL to_early%0d: got %b expected 0", k, bus.lsu_resp_valid);
            end
            tick();
        end
        n_checks++;
        if ({bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid} !== 3'b110 || bus.lsu_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL to_resp: got valid/err/ifu %b rdata %h expected 110 0000000000000000",
                     {bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid}, bus.lsu_rdata);
        end
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h55;
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_req_valid} !== 3'b000 || bus.lsu_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL to_late_ignored: got valids %b rdata %h expected 000 0000000000000000",
                     {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.mem_req_valid}, bus.lsu_rdata);
        end
        // response arriving on the last watchdog cycle must win over the error
        bus.lsu_req_valid = 1'b1;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = 64'h99;
            end
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        n_checks++;
        if ({bus.lsu_resp_valid, bus.lsu_resp_err} !== 2'b10 || bus.lsu_rdata !== 64'h99) begin
            n_fail++;
            $display("FAIL to_race: got valid/err %b rdata %h expected 10 0000000000000099",
                     {bus.lsu_resp_valid, bus.lsu_resp_err}, bus.lsu_rdata);
        end
        tick();
    endtask

    task automatic test_store();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wdata     = 64'h1122_3344_5566_7788;
        bus.lsu_wmask     = 8'h0F;
        #1;
        n_checks++;
        if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_ready: got %b expected 10", {bus.lsu_req_ready, bus.ifu_req_ready});
        end
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_addr      = 64'hDEAD;
        bus.lsu_wdata     = 64'hBEEF;
        bus.lsu_wmask     = 8'hF0;
        for (int c = 0; c < 5; c++) begin
            bus.mem_req_ready = (c == 4);
            #1;
            n_checks++;
            if ({bus.mem_req_valid, bus.mem_wen, bus.mem_wmask} !== {1'b1, 1'b1, 8'h0F} ||
                bus.mem_addr !== 64'h8000_1000 || bus.mem_wdata !== 64'h1122_3344_5566_7788) begin
                n_fail++;
                $display("FAIL st_issue%0d: got valid %b wen %b mask %h addr %h wdata %h expected 1 1 0f 0000000080001000 1122334455667788",
                         c, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr, bus.mem_wdata);
            end
            tick();
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++;
        if ({bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid} !== 3'b100 || bus.lsu_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL st_resp: got valid/err/ifu %b rdata %h expected 100 0000000000000000",
                     {bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid}, bus.lsu_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0040;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 5'b00000 ||
            {bus.mem_addr, bus.ifu_rdata, bus.lsu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got ctrl %b addr %h ifu %h lsu %h expected all 0",
                     {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready},
                     bus.mem_addr, bus.ifu_rdata, bus.lsu_rdata);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h66;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++;
        if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_resp: got %b expected 00", {bus.ifu_resp_valid, bus.lsu_resp_valid});
        end
        // with both requesting after reset the LSU must win; once it drops, the IFU is granted
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_tie: got ifu/lsu ready %b expected 01", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        bus.lsu_req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_ifu_alone: got ifu/lsu ready %b expected 10", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h77;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++;
        if ({bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid} !== 3'b100 || bus.ifu_rdata !== 64'h77) begin
            n_fail++;
            $display("FAIL rst_after_fetch: got valid/err/lsu %b rdata %h expected 100 0000000000000077",
                     {bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid}, bus.ifu_rdata);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_timeout();
        test_store();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Arbitrates one shared memory port between the instruction fetch unit (read-only) and the load/store unit (read/write) of the ysyx_22050612 core.
- Accepts one transaction at a time and drives it onto the memory port with a valid/ready request.
- Waits for a variable-latency response, then returns the data to the requester that owns the transaction.
- A watchdog terminates any transaction that gets no response.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; write mask width is DATA_W/8
- TIMEOUT, 255, max cycles in WAIT before error completion (must be at least 1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous reset, active-high
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  DATA_W  fetch data
- ifu_resp_err  out  1  qualifies ifu_resp_valid, timeout
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  one-cycle pulse, load data or store ack
- lsu_rdata  out  DATA_W  load data (0 for stores)
- lsu_resp_err  out  1  qualifies lsu_resp_valid, timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable (0 for IFU)
- mem_wdata  out  DATA_W  latched write data (0 for IFU)
- mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=IFU, owner=IFU, timeout counter=0. All outputs are 0: ready, resp_valid, resp_err, mem_req_valid, mem_* fields, rdata.
- Reset mid-transaction: transaction dropped, no response is ever issued for it. Any later mem_resp_valid is ignored while in IDLE.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and goes only to the granted requester: grant = valid && (other not valid || other was last_grant).
  - Round-robin on simultaneous requests; the first tie after reset goes to LSU.
  - On handshake: latch addr, wen, wdata, wmask (IFU: wen/wdata/wmask forced 0); set owner and last_grant; go to ISSUE.
  - At most one ready high per cycle.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: clear counter, go to WAIT.
  - Both requester readys are 0 in ISSUE, WAIT and RESP.
- WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - On mem_resp_valid: latch rdata (0 if owner is the LSU and wen=1), err=0, go to RESP.
  - If counter reaches TIMEOUT without a response: rdata=0, err=1, go to RESP. If mem_resp_valid arrives in that same cycle, the response wins.
- RESP:
  - owner's resp_valid=1 for exactly one cycle, with rdata and err; the non-owner's resp outputs stay 0.
  - Return to IDLE. A new grant is possible in the following cycle.
- mem_resp_valid outside WAIT is ignored.
- Minimum latency: accept at T, mem_req_valid at T+1, ready at T+1, response at T+2, resp_valid at T+3. Next accept at T+4.
- rdata outputs hold their value between pulses; only the pulse is meaningful.

Test Plan:
- Single fetch: ifu_addr=0x80000000, mem ready immediately, resp 1 cycle later with 0x00000413 -> ifu_resp_valid pulse at T+3, ifu_rdata=0x00000413, err=0, lsu_resp_valid stays 0.
- Simultaneous requests, 3 rounds (both valid every cycle) -> grant order LSU, IFU, LSU; never both readys high.
- Store: lsu_wen=1, addr=0x80001000, wdata=0x1122334455667788, wmask=0x0F, mem_req_ready delayed 4 cycles -> mem_* fields stable throughout ISSUE; lsu_resp_valid pulse with rdata=0.
- Timeout with TIMEOUT=8: no mem_resp_valid -> lsu_resp_err=1 and rdata=0 exactly 8 cycles after entering WAIT. A late mem_resp_valid arriving in IDLE is ignored.
- rst asserted in WAIT -> next cycle all outputs 0, no resp pulse. A following IFU request completes normally and wins the first grant only if LSU is idle.
